adc_spi_responder: RTL and testbench
====================================

# adc_spi_responder

Cycle-accurate SPI responder for the two-channel ADC link, the device end of the serial conversation our SPI initiator drives. It decodes the 4-bit command (start, sgl, odd/channel, msbf), snapshots the selected sample, and shifts a null bit plus a DATA_BITS-wide result out on sdo. It sits in the FPGA as the on-chip ADC model for loopback, board bring-up without the ADC fitted, and the initiator's bench.

## Interface
- DATA_BITS, 12: result width shifted out per frame.
- sck  in  1  clock; all sampling and sdo updates on posedge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- chip_en  in  1  frame enable from the initiator; 1 = idle/deselected, 0 = frame active.
- sdi  in  1  command bits from the initiator.
- sample0  in  DATA_BITS  channel 0 value, unsigned.
- sample1  in  DATA_BITS  channel 1 value, unsigned.
- sdo  out  1  registered serial result.
- busy  out  1  high from start-bit decode until return to IDLE.
- cmd_sgl  out  1  latched sgl bit of the last accepted command.
- cmd_odd  out  1  latched channel bit of the last accepted command.
- frame_done  out  1  one-cycle pulse on completion of a full frame.
- frame_error  out  1  one-cycle pulse when chip_en rises mid-frame.

## Operation
- States: IDLE, CMD, NULL, DATA, DONE.
- IDLE: sdo=0. On a posedge with chip_en=0 and sdi=1 (start bit), go to CMD and clear the bit counter. Leading zeros with chip_en=0 are ignored.
- CMD: capture sgl, odd, then msbf on three successive posedges.
  - On the msbf edge, snapshot the result into the shift register, drive sdo=0 (null bit) and go to NULL.
  - cmd_sgl/cmd_odd update on that same edge.
- Result selection:
  - sgl=1: sample0 if odd=0, sample1 if odd=1.
  - sgl=0 (pseudo-differential): odd=0 gives sample0−sample1; odd=1 gives sample1−sample0. Computed at DATA_BITS+1 bits and clamped to 0 when negative.
- NULL: next posedge drives the first result bit and goes to DATA.
  - msbf=1: bit DATA_BITS−1 first.
  - msbf=0: bit 0 first (LSB-first).
- DATA: one bit per posedge. After bit DATA_BITS has been held for one cycle, the next posedge goes to DONE with sdo=0 and frame_done=1.
- DONE: sdo=0. chip_en=1 returns the block to IDLE.
- chip_en=1 sampled in CMD, NULL or DATA: go to IDLE, sdo=0, frame_error=1 for one cycle. No frame_done.
- Reset values: state IDLE, sdo=0, busy=0, cmd_sgl=0, cmd_odd=0, frame_done=0, frame_error=0, shift register and counter 0.
- Asynchronous reset mid-frame: immediate return to reset values. No error pulse.

## Timing
- Edge numbering: P1 is the posedge that samples the start bit. P2 samples sgl, P3 samples odd, P4 samples msbf.
- After P4 sdo=0 (null). After P5 sdo = first result bit. After P(4+k) sdo = result bit k, for k = 1..DATA_BITS.
- Default 12 bits: last bit is valid P16–P17. At P17 the block enters DONE with frame_done high P17–P18. At P18, chip_en=1 gives IDLE.
- This lines up with an initiator that drops chip_en for start/sgl/channel/msbf, one null cycle, then 12 read cycles.
- The sample snapshot is taken at P4 only. Later changes to sample0/sample1 do not affect the frame in flight.
- busy rises at P1 and falls on the edge entering IDLE.
- A start bit is accepted on the edge after DONE→IDLE at the earliest (no back-to-back start inside DONE).
- chip_en=1 and the last bit on the same edge: completion wins (DONE, frame_done), no frame_error.

## Structure
- Package adc_spi_pkg holds:
  - the state enum (logic [2:0]: IDLE, CMD, NULL, DATA, DONE);
  - the DATA_BITS default;
  - the command field order constants (start, sgl, odd, msbf).
- One sub-module: spi_shift_out, a parameterized load/shift register with MSB-first/LSB-first select, owning sdo.
- Command decode, the difference/clamp, and the FSM stay in adc_spi_responder.

## Test plan
- sample0=0xABC, command 1,1,0,1: sdo after P4..P16 = 0, 1010 1011 1100; frame_done at P17; cmd_sgl=1, cmd_odd=0.
- sample1=0x005, command 1,1,1,0: null bit, then LSB-first 1010 0000 0000.
- sgl=0, odd=0, sample0=0x100, sample1=0x0F0: result 0x010. Swapping the values gives a clamped result of 0x000.
- Three leading zeros with chip_en=0 before the start bit: frame shifts identically, just delayed by three cycles.
- chip_en raised after the 5th data bit: frame_error pulses, sdo=0, busy=0, no frame_done. The next frame decodes correctly.
- Reset asserted during DATA, then sample0 changed at P5 of the next frame: all outputs return to 0 immediately. The new frame outputs the P4 snapshot, not the changed value.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC SPI responder:
// FSM state encoding, default result width and command field order.
package adc_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        NULL,
        DATA,
        DONE
    } state_t;

    localparam int unsigned ADC_DATA_BITS = 12;

    // Position of each field within the command, counted from the start bit.
    localparam int unsigned FIELD_START = 0;
    localparam int unsigned FIELD_SGL   = 1;
    localparam int unsigned FIELD_ODD   = 2;
    localparam int unsigned FIELD_MSBF  = 3;

endpackage

// File: rtl/spi_shift_out.sv
// Load/shift register driving the registered serial output.
// A load emits the null bit; each shift emits the next bit in the latched order.
module spi_shift_out #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic             msbf,
    input  logic [WIDTH-1:0] load_data,
    output logic             sdo
);

    logic [WIDTH-1:0] shreg;
    logic             msbf_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg  <= '0;
            msbf_r <= 1'b0;
            sdo    <= 1'b0;
        end else if (load) begin
            shreg  <= load_data;
            msbf_r <= msbf;
            sdo    <= 1'b0;
        end else if (shift) begin
            if (msbf_r) begin
                sdo   <= shreg[WIDTH-1];
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                sdo   <= shreg[0];
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end else if (clear) begin
            sdo <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_spi_responder.sv
// Device end of the two-channel ADC SPI link: decodes start/sgl/odd/msbf,
// snapshots the selected (or clamped differential) sample and shifts it out.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int unsigned DATA_BITS = ADC_DATA_BITS
) (
    input  logic                 sck,
    input  logic                 reset,
    input  logic                 chip_en,
    input  logic                 sdi,
    input  logic [DATA_BITS-1:0] sample0,
    input  logic [DATA_BITS-1:0] sample1,
    output logic                 sdo,
    output logic                 busy,
    output logic                 cmd_sgl,
    output logic                 cmd_odd,
    output logic                 frame_done,
    output logic                 frame_error
);

    localparam int unsigned CW = ($clog2(DATA_BITS + 1) < 2) ? 2 : $clog2(DATA_BITS + 1);

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [CW-1:0]  field;
    logic           sgl_t, sgl_n, odd_t, odd_n;
    logic           cmd_sgl_n, cmd_odd_n, done_n, err_n;
    logic           load, shift, clear;
    logic [DATA_BITS:0]   diff;
    logic [DATA_BITS-1:0] result;

    assign field = cnt + CW'(FIELD_SGL);
    assign busy  = (state != IDLE);

    // Pseudo-differential result is formed one bit wider so a borrow marks "negative".
    always_comb begin
        diff = '0;
        if (sgl_t) begin
            result = odd_t ? sample1 : sample0;
        end else begin
            diff   = odd_t ? ({1'b0, sample1} - {1'b0, sample0})
                           : ({1'b0, sample0} - {1'b0, sample1});
            result = diff[DATA_BITS] ? '0 : diff[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge sck or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sgl_t       <= 1'b0;
            odd_t       <= 1'b0;
            cmd_sgl     <= 1'b0;
            cmd_odd     <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sgl_t       <= sgl_n;
            odd_t       <= odd_n;
            cmd_sgl     <= cmd_sgl_n;
            cmd_odd     <= cmd_odd_n;
            frame_done  <= done_n;
            frame_error <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sgl_n     = sgl_t;
        odd_n     = odd_t;
        cmd_sgl_n = cmd_sgl;
        cmd_odd_n = cmd_odd;
        done_n    = 1'b0;
        err_n     = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (!chip_en && sdi) begin
                    state_n = CMD;
                    cnt_n   = '0;
                end
            end
            CMD: begin
                if (chip_en) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    clear   = 1'b1;
                    err_n   = 1'b1;
                end else if (field == CW'(FIELD_MSBF)) begin
                    load      = 1'b1;
                    cmd_sgl_n = sgl_t;
                    cmd_odd_n = odd_t;
                    cnt_n     = '0;
                    state_n   = NULL;
                end else begin
                    if (field == CW'(FIELD_SGL)) sgl_n = sdi;
                    if (field == CW'(FIELD_ODD)) odd_n = sdi;
                    cnt_n = cnt + CW'(1);
                end
            end
            NULL: begin
                if (chip_en) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    clear   = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    shift   = 1'b1;
                    cnt_n   = CW'(1);
                    state_n = DATA;
                end
            end
            DATA: begin
                // Completion is checked before chip_en so a deselect on the final edge is not an error.
                if (cnt == CW'(DATA_BITS)) begin
                    state_n = DONE;
                    cnt_n   = '0;
                    clear   = 1'b1;
                    done_n  = 1'b1;
                end else if (chip_en) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    clear   = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    shift = 1'b1;
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                if (chip_en) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                clear   = 1'b1;
            end
        endcase
    end

    spi_shift_out #(
        .WIDTH(DATA_BITS)
    ) u_shift (
        .clk       (sck),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .clear     (clear),
        .msbf      (sdi),
        .load_data (result),
        .sdo       (sdo)
    );

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed and randomized frames against an arithmetic model of the ADC result
// and the fixed frame timeline (null bit after P4, bit k after P4+k, done at P17).
module tb_adc_spi_responder;

    localparam int unsigned DB = 12;

    logic          sck = 1'b0;
    logic          reset;
    logic          chip_en;
    logic          sdi;
    logic [DB-1:0] sample0;
    logic [DB-1:0] sample1;
    logic          sdo, busy, cmd_sgl, cmd_odd, frame_done, frame_error;

    int checks = 0;
    int errors = 0;

    adc_spi_responder #(
        .DATA_BITS(DB)
    ) dut (
        .sck         (sck),
        .reset       (reset),
        .chip_en     (chip_en),
        .sdi         (sdi),
        .sample0     (sample0),
        .sample1     (sample1),
        .sdo         (sdo),
        .busy        (busy),
        .cmd_sgl     (cmd_sgl),
        .cmd_odd     (cmd_odd),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    always #5 sck = ~sck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    function automatic logic [DB-1:0] model(input bit sgl, input bit odd,
                                            input logic [DB-1:0] a, input logic [DB-1:0] b);
        int d;
        if (sgl) return odd ? b : a;
        d = odd ? (int'(b) - int'(a)) : (int'(a) - int'(b));
        return (d < 0) ? '0 : DB'(d);
    endfunction

    // abort_at / reset_at: act just before data bit k would be shifted (0 = never).
    task automatic do_frame(input bit sgl, input bit odd, input bit msbf, input int lead,
                            input int abort_at, input int reset_at, input bit ce_on_last);
        logic [DB-1:0] r;
        logic          exp_bit;
        r = model(sgl, odd, sample0, sample1);
        chip_en = 1'b0;
        sdi     = 1'b0;
        for (int i = 0; i < lead; i++) begin
            tick();
            chk("lead_busy", busy, 0);
            chk("lead_sdo", sdo, 0);
        end
        sdi = 1'b1;
        tick();
        chk("p1_busy", busy, 1);
        chk("p1_sdo", sdo, 0);
        sdi = sgl;
        tick();
        sdi = odd;
        tick();
        sdi = msbf;
        tick();
        chk("p4_null", sdo, 0);
        chk("p4_cmd_sgl", cmd_sgl, sgl);
        chk("p4_cmd_odd", cmd_odd, odd);
        chk("p4_busy", busy, 1);
        sdi     = 1'($urandom);
        sample0 = DB'($urandom);
        sample1 = DB'($urandom);
        for (int k = 1; k <= int'(DB); k++) begin
            if (reset_at == k) begin
                reset = 1'b1;
                #1;
                chk("rst_sdo", sdo, 0);
                chk("rst_busy", busy, 0);
                chk("rst_sgl", cmd_sgl, 0);
                chk("rst_odd", cmd_odd, 0);
                chk("rst_done", frame_done, 0);
                chk("rst_err", frame_error, 0);
                #1;
                reset   = 1'b0;
                chip_en = 1'b1;
                tick();
                chk("rst_no_err", frame_error, 0);
                return;
            end
            if (abort_at == k) begin
                chip_en = 1'b1;
                tick();
                chk("abort_err", frame_error, 1);
                chk("abort_sdo", sdo, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", frame_done, 0);
                tick();
                chk("abort_err_pulse", frame_error, 0);
                return;
            end
            tick();
            exp_bit = msbf ? r[DB-k] : r[k-1];
            chk($sformatf("bit%0d", k), sdo, exp_bit);
            chk("data_done", frame_done, 0);
            sdi = 1'($urandom);
        end
        if (ce_on_last) chip_en = 1'b1;
        tick();
        chk("p17_done", frame_done, 1);
        chk("p17_err", frame_error, 0);
        chk("p17_sdo", sdo, 0);
        chk("p17_busy", busy, 1);
        if (!ce_on_last) begin
            sdi = 1'b1;
            tick();
            chk("done_hold_busy", busy, 1);
            chk("done_pulse", frame_done, 0);
            chk("done_sdo", sdo, 0);
            chip_en = 1'b1;
        end
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_done", frame_done, 0);
        chk("idle_sdo", sdo, 0);
    endtask

    initial begin
        reset   = 1'b1;
        chip_en = 1'b1;
        sdi     = 1'b0;
        sample0 = '0;
        sample1 = '0;
        tick();
        tick();
        chk("reset_sdo", sdo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_sgl", cmd_sgl, 0);
        chk("reset_odd", cmd_odd, 0);
        chk("reset_done", frame_done, 0);
        chk("reset_err", frame_error, 0);
        reset = 1'b0;
        tick();
        chk("post_reset_busy", busy, 0);

        sample0 = 12'hABC; sample1 = 12'h123;
        do_frame(1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b0);

        sample0 = 12'h777; sample1 = 12'h005;
        do_frame(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);

        sample0 = 12'h100; sample1 = 12'h0F0;
        do_frame(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0);

        sample0 = 12'h0F0; sample1 = 12'h100;
        do_frame(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0);

        sample0 = 12'hABC;
        do_frame(1'b1, 1'b0, 1'b1, 3, 0, 0, 1'b0);

        sample0 = 12'h5A3; sample1 = 12'h3C4;
        do_frame(1'b0, 1'b1, 1'b1, 1, 6, 0, 1'b0);
        sample0 = 12'h5A3; sample1 = 12'h3C4;
        do_frame(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0);

        sample0 = 12'hFFF; sample1 = 12'h001;
        do_frame(1'b1, 1'b1, 1'b1, 0, 0, 4, 1'b0);
        sample0 = 12'h9D2; sample1 = 12'h0AA;
        do_frame(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        sample0 = 12'h321; sample1 = 12'h123;
        do_frame(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);

        for (int n = 0; n < 24; n++) begin
            sample0 = DB'($urandom);
            sample1 = DB'($urandom);
            do_frame(1'($urandom), 1'($urandom), 1'($urandom),
                     int'($urandom_range(3, 0)), 0, 0, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
